// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the count-up stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned NUM_DIGITS  = 6;
  localparam int unsigned DIGIT_MAX_9 = 9;
  localparam int unsigned DIGIT_MAX_5 = 5;

  // Digit order is sec_1, sec_10, min_1, min_10, hr_1, hr_10; tens of sec/min roll at 5.
  function automatic int unsigned digit_max(input int unsigned idx);
    return (idx == 1 || idx == 3) ? DIGIT_MAX_5 : DIGIT_MAX_9;
  endfunction

endpackage

// File: rtl/stopwatch_up_if.sv
// Button inputs and display/status outputs of the count-up stopwatch.
interface stopwatch_up_if;
  import stopwatch_pkg::*;

  logic               start;
  logic               lap;
  logic               clear;
  logic [DIGIT_W-1:0] hr_10;
  logic [DIGIT_W-1:0] hr_1;
  logic [DIGIT_W-1:0] min_10;
  logic [DIGIT_W-1:0] min_1;
  logic [DIGIT_W-1:0] sec_10;
  logic [DIGIT_W-1:0] sec_1;
  logic               running;
  logic               lap_active;
  logic               overflow;

  modport master (
    output start, lap, clear,
    input  hr_10, hr_1, min_10, min_1, sec_10, sec_1, running, lap_active, overflow
  );

  modport slave (
    input  start, lap, clear,
    output hr_10, hr_1, min_10, min_1, sec_10, sec_1, running, lap_active, overflow
  );

endinterface

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit 0..MAX with synchronous clear and ripple carry to the next digit.
module stopwatch_bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = DIGIT_MAX_9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry_out
);

  logic [DIGIT_W-1:0] r_digit;

  // Digit register: clear wins, otherwise advance and wrap at MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit <= '0;
    end else if (clr) begin
      r_digit <= '0;
    end else if (inc) begin
      r_digit <= (r_digit == DIGIT_W'(MAX)) ? '0 : r_digit + DIGIT_W'(1);
    end
  end

  assign digit     = r_digit;
  assign carry_out = inc && (r_digit == DIGIT_W'(MAX));

endmodule

// File: rtl/stopwatch_up.sv
// Count-up stopwatch HH:MM:SS in BCD with start/pause, lap hold and clear.
module stopwatch_up
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic          clk,
  input  logic          reset,
  stopwatch_up_if.slave sw
);

  localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned NUM_BTN = 3;

  logic [NUM_BTN-1:0] w_btn;
  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_prev;
  logic [NUM_BTN-1:0] w_pulse;
  logic               w_start;
  logic               w_lap;
  logic               w_clear;

  state_t                                 r_state;
  logic [PRESC_W-1:0]                     r_presc;
  logic                                   r_running;
  logic                                   r_lap_active;
  logic                                   r_overflow;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     r_snap;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     w_digits;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     w_disp;
  logic [NUM_DIGITS:0]                    w_chain;
  logic                                   w_tick;
  logic                                   w_clr;

  assign w_btn = {sw.clear, sw.lap, sw.start};

  // Two-flop synchronizers plus the previous-level register for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_pulse = r_sync2 & ~r_prev;
  assign w_start = w_pulse[0];
  assign w_lap   = w_pulse[1];
  assign w_clear = w_pulse[2];

  assign w_tick = (r_state == RUN) && (r_presc == PRESC_W'(CLK_HZ - 1));
  assign w_clr  = w_clear && (r_state != RUN);

  // Control FSM with prescaler, lap snapshot and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
      r_overflow   <= 1'b0;
      r_snap       <= '0;
    end else if (w_clr) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
      r_overflow   <= 1'b0;
      r_snap       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
          if (w_chain[NUM_DIGITS]) begin
            r_overflow <= 1'b1;
          end
          if (w_start) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end else if (w_lap) begin
            r_lap_active <= ~r_lap_active;
            if (!r_lap_active) begin
              r_snap <= w_digits;
            end
          end
        end
        PAUSE: begin
          if (w_start) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end else if (w_lap) begin
            r_lap_active <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Six-digit ripple chain; the final carry marks the 99:59:59 wrap.
  assign w_chain[0] = w_tick;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    stopwatch_bcd_digit #(
      .MAX(digit_max(gi))
    ) u_digit (
      .clk       (clk),
      .reset     (reset),
      .clr       (w_clr),
      .inc       (w_chain[gi]),
      .digit     (w_digits[gi]),
      .carry_out (w_chain[gi+1])
    );
  end

  assign w_disp = r_lap_active ? r_snap : w_digits;

  assign sw.sec_1      = w_disp[0];
  assign sw.sec_10     = w_disp[1];
  assign sw.min_1      = w_disp[2];
  assign sw.min_10     = w_disp[3];
  assign sw.hr_1       = w_disp[4];
  assign sw.hr_10      = w_disp[5];
  assign sw.running    = r_running;
  assign sw.lap_active = r_lap_active;
  assign sw.overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_up.sv
// Directed bench for stopwatch_up with CLK_HZ=10 (one second = 10 clk).
module tb_stopwatch_up;

  logic        clk = 1'b0;
  logic        reset;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] pre_val;

  stopwatch_up_if sw();

  stopwatch_up #(
    .CLK_HZ(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] disp();
    return {sw.hr_10, sw.hr_1, sw.min_10, sw.min_1, sw.sec_10, sw.sec_1};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: sw.start = v;
      1: sw.lap   = v;
      default: sw.clear = v;
    endcase
  endtask

  // Rise at a falling edge, hold, release; returns after the third rising edge.
  task automatic press(input int which, input int hold);
    set_btn(which, 1'b1);
    step(hold);
    set_btn(which, 1'b0);
    step(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
  endtask

  // Deposit a BCD count into the digit registers between clock edges.
  task automatic preload(input logic [23:0] v);
    pre_val = v;
    force dut.g_digit[0].u_digit.r_digit = pre_val[3:0];
    force dut.g_digit[1].u_digit.r_digit = pre_val[7:4];
    force dut.g_digit[2].u_digit.r_digit = pre_val[11:8];
    force dut.g_digit[3].u_digit.r_digit = pre_val[15:12];
    force dut.g_digit[4].u_digit.r_digit = pre_val[19:16];
    force dut.g_digit[5].u_digit.r_digit = pre_val[23:20];
    #1;
    release dut.g_digit[0].u_digit.r_digit;
    release dut.g_digit[1].u_digit.r_digit;
    release dut.g_digit[2].u_digit.r_digit;
    release dut.g_digit[3].u_digit.r_digit;
    release dut.g_digit[4].u_digit.r_digit;
    release dut.g_digit[5].u_digit.r_digit;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    sw.start = 1'b0;
    sw.lap   = 1'b0;
    sw.clear = 1'b0;
    step(2);
    check("rst_disp", disp(), 24'h000000);
    check("rst_running", 24'(sw.running), 24'd0);
    check("rst_lap", 24'(sw.lap_active), 24'd0);
    check("rst_ovf", 24'(sw.overflow), 24'd0);
    reset = 1'b0;
    step(2);

    // Basic count: 125 run cycles after start
    press(0, 1);
    check("start_running", 24'(sw.running), 24'd1);
    step(125);
    check("run125_disp", disp(), 24'h000012);
    check("run125_running", 24'(sw.running), 24'd1);

    // Pause keeps the count and the partial second; long hold gives one pulse
    do_reset();
    press(0, 1);
    step(35);
    press(0, 4);
    check("pause_running", 24'(sw.running), 24'd0);
    check("pause_disp", disp(), 24'h000003);
    step(100);
    check("pause_hold_disp", disp(), 24'h000003);
    press(0, 1);
    check("resume_running", 24'(sw.running), 24'd1);
    step(2);
    check("presc_kept", disp(), 24'h000004);
    step(63);
    check("run100_disp", disp(), 24'h000010);

    // Hour carry and full wrap
    do_reset();
    press(0, 1);
    preload(24'h005959);
    step(9);
    check("pre_005959", disp(), 24'h005959);
    step(1);
    check("carry_010000", disp(), 24'h010000);
    preload(24'h995959);
    step(9);
    check("pre_995959", disp(), 24'h995959);
    check("pre_wrap_ovf", 24'(sw.overflow), 24'd0);
    step(1);
    check("wrap_disp", disp(), 24'h000000);
    check("wrap_ovf", 24'(sw.overflow), 24'd1);
    check("wrap_running", 24'(sw.running), 24'd1);

    // Lap freeze while live count advances
    step(50);
    check("lap_pre_disp", disp(), 24'h000005);
    press(1, 1);
    check("lap_on", 24'(sw.lap_active), 24'd1);
    check("lap_on_disp", disp(), 24'h000005);
    step(30);
    check("lap_frozen", disp(), 24'h000005);
    press(1, 1);
    check("lap_off", 24'(sw.lap_active), 24'd0);
    check("lap_off_disp", disp(), 24'h000008);

    // Clear ignored while running
    press(2, 1);
    check("clr_run_disp", disp(), 24'h000008);
    check("clr_run_running", 24'(sw.running), 24'd1);
    check("clr_run_ovf", 24'(sw.overflow), 24'd1);

    // Lap armed, then pause; lap in pause only drops the hold
    press(1, 1);
    check("lap2_on", 24'(sw.lap_active), 24'd1);
    press(0, 1);
    check("pause2_running", 24'(sw.running), 24'd0);
    check("pause2_lap", 24'(sw.lap_active), 24'd1);
    check("pause2_disp", disp(), 24'h000009);
    press(1, 1);
    check("pause_lap_off", 24'(sw.lap_active), 24'd0);
    check("pause_lap_running", 24'(sw.running), 24'd0);

    // start and clear together in PAUSE: clear wins
    sw.start = 1'b1;
    sw.clear = 1'b1;
    step(1);
    sw.start = 1'b0;
    sw.clear = 1'b0;
    step(2);
    check("sc_disp", disp(), 24'h000000);
    check("sc_running", 24'(sw.running), 24'd0);
    check("sc_ovf", 24'(sw.overflow), 24'd0);
    check("sc_lap", 24'(sw.lap_active), 24'd0);
    press(1, 1);
    step(20);
    check("idle_lap_ignored", 24'(sw.lap_active), 24'd0);
    check("idle_disp", disp(), 24'h000000);

    // Asynchronous reset mid-count
    press(0, 1);
    step(70);
    check("pre_rst_disp", disp(), 24'h000007);
    reset = 1'b1;
    #1;
    check("async_rst_disp", disp(), 24'h000000);
    check("async_rst_running", 24'(sw.running), 24'd0);
    step(1);
    reset = 1'b0;
    step(2);
    press(0, 1);
    step(9);
    check("post_rst_r9", disp(), 24'h000000);
    step(1);
    check("post_rst_r10", disp(), 24'h000001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
